io_bus_arbiter: RTL and testbench
=================================

# io_bus_arbiter

Sequencer and two-way round-robin arbiter for the peripheral I/O bus. It sits between the address-space splitter's I/O window and the ioslot instances. It shares the bus between the CPU load/store port (requester 0) and the DMA engine (requester 1). It runs one transaction at a time, drives the read/write strobes, waits for the slot's ready, and returns data and a done/error pulse, with a bounded timeout.

## Interface
Parameters:
- ADDR_WIDTH, `IO_ADDR_WIDTH (32): I/O address width.
- DATA_WIDTH, `IO_DATA_WIDTH (32): I/O data width.
- TIMEOUT_CYCLES, 16: maximum strobe cycles before an access is aborted; legal range 2..255.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  2  per-requester access request; held high until the matching done.
- we  in  2  per-requester 1 = write, 0 = read; sampled with req.
- addr0, addr1  in  ADDR_WIDTH  per-requester byte address.
- wdata0, wdata1  in  DATA_WIDTH  per-requester write data.
- done  out  2  one-cycle completion pulse, one bit per requester.
- err  out  1  valid with done; 1 = timeout.
- rdata  out  DATA_WIDTH  read data, valid with done on a read.
- bus_read, bus_write  out  1  strobes to the ioslot bank.
- bus_addr  out  ADDR_WIDTH  latched transaction address.
- bus_wdata  out  DATA_WIDTH  latched write data.
- bus_rdata  in  DATA_WIDTH  data returned by the selected slot.
- bus_ready  in  1  slot completion; OR of all slot ready lines.

## Operation
FSM states: IDLE, ACCESS, RESP.

- **IDLE**
  - With req == 0, stay in IDLE.
  - With any req bit set, choose a winner:
    - If only one bit is set, that requester wins.
    - If both bits are set, the winner is the requester not recorded in last_gnt.
  - Latch the winner's addr, wdata and we, plus its index in gnt_idx.
  - Clear the timeout counter and go to ACCESS.
- **ACCESS**
  - Assert bus_read when the latched we = 0, and bus_write when the latched we = 1. Exactly one strobe is high.
  - bus_addr and bus_wdata hold the latched values.
  - On an edge where bus_ready = 1: capture bus_rdata into rdata, clear err, go to RESP.
  - Otherwise, if the counter equals TIMEOUT_CYCLES-1: set err = 1, force rdata to 0, go to RESP.
  - Otherwise, increment the counter.
- **RESP**
  - done[gnt_idx] = 1 for this cycle only. err and rdata are valid in this cycle.
  - Write gnt_idx into last_gnt, then return to IDLE.
- Requests are not re-arbitrated inside a transaction.
- If a requester drops req during ACCESS, the access still completes and done still pulses.
- On a write, rdata holds its previous value.
- The counter is $clog2(TIMEOUT_CYCLES) bits wide and never wraps: it saturates at the abort point.

## Timing
- **Reset:** asynchronous assert of rst_n = 0 forces the following at once:
  - state = IDLE; done = 0, err = 0, rdata = 0;
  - bus_read = 0, bus_write = 0, bus_addr = 0, bus_wdata = 0;
  - last_gnt = 1, so the CPU wins the first contested arbitration.
- **Mid-transaction reset:** the transaction is dropped with no done pulse.
- **Release:** deassertion is synchronous to clk.
- **Latency:**
  - req is sampled high at edge E.
  - Strobes are high from E+1.
  - bus_ready is sampled high at edge E+1+n (n ≥ 0).
  - done is high in the cycle after that edge.
  - Minimum req-to-done is 2 cycles; maximum is 1+TIMEOUT_CYCLES.
- **Next transaction:** earliest strobe is 2 cycles after done (RESP → IDLE → ACCESS). The bus is never idle-strobed in RESP or IDLE.
- **bus_ready outside ACCESS** is ignored.
- **Ready on the final count cycle:** ready wins, so err = 0.
- **Requester re-issue:** after done, a requester may keep req high. It is treated as a new request in the next IDLE, subject to round-robin.

## Structure
- Add to constants.v:
  - state encodings `IOARB_IDLE = 2'd0, `IOARB_ACCESS = 2'd1, `IOARB_RESP = 2'd2;
  - `IOARB_TIMEOUT default 16.
- Single module, with no sub-module required.
- The two-input round-robin picker may be a function inside the module.
- Tristating to the inout ioslot data bus stays in the top-level wrapper. This block uses split rdata/wdata.

## Test plan
- **Single CPU read:** req = 01, we = 00, addr0 = 0x100; slot asserts bus_ready on the 1st ACCESS cycle with bus_rdata = 0xDEADBEEF. Required: bus_read high for 1 cycle, done = 01 two cycles after req, rdata = 0xDEADBEEF, err = 0.
- **DMA write with wait states:** req = 10, we = 10, addr1 = 0x104, wdata1 = 0x55AA; ready after 3 cycles. Required: bus_write high for 4 cycles, bus_wdata = 0x55AA, done = 10, err = 0.
- **Contention:** req = 11 held from reset, ready immediate. Required: grants alternate CPU, DMA, CPU, DMA; done pulses 01, 10, 01, 10, spaced 3 cycles apart.
- **Timeout:** CPU read to unmapped 0x800, bus_ready never asserted. Required: strobe high exactly 16 cycles, done = 01 with err = 1 and rdata = 0.
- **Ready on last count:** bus_ready on the 16th ACCESS cycle. Required: err = 0 and data captured.
- **Reset mid-access:** rst_n pulled low in the 2nd ACCESS cycle. Required: bus_read drops immediately, no done pulse, and after release a pending DMA request is granted first ahead of the CPU.

Source files
------------

// File: rtl/io_bus_arbiter_pkg.sv
// io_bus_arbiter_pkg: shared widths, FSM encoding and round-robin picker for the I/O bus arbiter.
package io_bus_arbiter_pkg;
  localparam int IO_ADDR_WIDTH = 32;
  localparam int IO_DATA_WIDTH = 32;
  localparam int IOARB_TIMEOUT = 16;
  typedef enum logic [1:0] {
    IOARB_IDLE   = 2'd0,
    IOARB_ACCESS = 2'd1,
    IOARB_RESP   = 2'd2
  } ioarb_state_e;
  // Contested requests go to whoever was not served last.
  function automatic logic rr_pick(input logic [1:0] req, input logic last_gnt);
    return (&req) ? ~last_gnt : req[1];
  endfunction
endpackage

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: two-way round-robin sequencer for the peripheral I/O bus, one
// transaction at a time with a bounded ready timeout.
module io_bus_arbiter
  import io_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = IO_ADDR_WIDTH,
  parameter int DATA_WIDTH     = IO_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = IOARB_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic [1:0]            done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  bus_read,
  output logic                  bus_write,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ready
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
  ioarb_state_e          state_q;
  logic [CW-1:0]         cnt_q;
  logic                  gnt_q, last_gnt_q, we_q, err_q, rd_q, wr_q, gnt_d;
  logic [1:0]            done_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  assign gnt_d     = rr_pick(req, last_gnt_q);
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign bus_read  = rd_q;
  assign bus_write = wr_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IOARB_IDLE;
      cnt_q      <= '0;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      done_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      case (state_q)
        IOARB_IDLE: if (|req) begin
          gnt_q   <= gnt_d;
          we_q    <= we[gnt_d];
          addr_q  <= gnt_d ? addr1 : addr0;
          wdata_q <= gnt_d ? wdata1 : wdata0;
          rd_q    <= ~we[gnt_d];
          wr_q    <= we[gnt_d];
          cnt_q   <= '0;
          state_q <= IOARB_ACCESS;
        end
        IOARB_ACCESS: if (bus_ready || cnt_q == CNT_MAX) begin
          // Ready on the final count still counts as success.
          err_q   <= ~bus_ready;
          rdata_q <= !bus_ready ? '0 : we_q ? rdata_q : bus_rdata;
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          done_q  <= {gnt_q, ~gnt_q};
          state_q <= IOARB_RESP;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
        IOARB_RESP: begin
          done_q     <= 2'b00;
          last_gnt_q <= gnt_q;
          state_q    <= IOARB_IDLE;
        end
        default: state_q <= IOARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: directed vectors for the I/O bus arbiter with hand-computed expectations.
module tb_io_bus_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0, bus_ready = 1'b0;
  logic [1:0]  req = 2'b00, we = 2'b00;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0, bus_rdata = '0;
  logic [1:0]  done;
  logic        err, bus_read, bus_write;
  logic [31:0] rdata, bus_addr, bus_wdata;
  int          total = 0, bad = 0;
  int          n_rd, n_wr, lat, nd;
  logic [1:0]  dn;
  logic [31:0] a_seen, w_seen, first_addr;
  logic [1:0]  dseq [8];
  int          dcyc [8];

  io_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done(done), .err(err), .rdata(rdata),
    .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Acts as the slot: raises ready during the rdy_at-th strobe cycle (0 = never).
  task automatic xact(input int rdy_at, input bit drop);
    n_rd = 0; n_wr = 0; lat = 0; dn = 2'b00;
    while (dn == 2'b00 && lat < 40) begin
      tick;
      lat++;
      if (bus_read || bus_write) begin
        if (n_rd + n_wr == 0) begin
          a_seen = bus_addr;
          w_seen = bus_wdata;
        end
        n_rd += int'(bus_read);
        n_wr += int'(bus_write);
      end
      if (drop && n_rd + n_wr == 1) req = 2'b00;
      bus_ready = rdy_at > 0 && n_rd + n_wr == rdy_at;
      dn = done;
    end
    bus_ready = 1'b0;
    chk("done_seen", 32'(dn != 2'b00), 32'd1);
  endtask

  initial begin
    #1;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_strobes", 32'({bus_read, bus_write}), 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick;

    req = 2'b01; we = 2'b00; addr0 = 32'h100; addr1 = 32'h999; bus_rdata = 32'hDEADBEEF;
    xact(1, 1'b0);
    chk("t1_nrd", n_rd, 1);
    chk("t1_nwr", n_wr, 0);
    chk("t1_addr", a_seen, 32'h100);
    chk("t1_done", 32'(dn), 32'd1);
    chk("t1_lat", lat, 2);
    chk("t1_rdata", rdata, 32'hDEADBEEF);
    chk("t1_err", 32'(err), 32'd0);
    req = 2'b00;
    tick;
    chk("t1_done_clr", 32'(done), 32'd0);

    req = 2'b10; we = 2'b10; addr1 = 32'h104; wdata1 = 32'h55AA; wdata0 = 32'h1111; bus_rdata = 32'hBAD0BAD0;
    xact(4, 1'b1);
    chk("t2_nwr", n_wr, 4);
    chk("t2_nrd", n_rd, 0);
    chk("t2_addr", a_seen, 32'h104);
    chk("t2_wdata", w_seen, 32'h55AA);
    chk("t2_done", 32'(dn), 32'd2);
    chk("t2_err", 32'(err), 32'd0);
    chk("t2_rdata_hold", rdata, 32'hDEADBEEF);
    tick;

    req = 2'b01; we = 2'b00; addr0 = 32'h800; bus_rdata = 32'hFFFF0000;
    xact(0, 1'b0);
    chk("t4_nrd", n_rd, 16);
    chk("t4_lat", lat, 17);
    chk("t4_done", 32'(dn), 32'd1);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_rdata", rdata, 32'd0);
    req = 2'b00;
    tick;

    addr0 = 32'h10; req = 2'b01; bus_rdata = 32'h12345678;
    xact(16, 1'b0);
    chk("t5_nrd", n_rd, 16);
    chk("t5_done", 32'(dn), 32'd1);
    chk("t5_err", 32'(err), 32'd0);
    chk("t5_rdata", rdata, 32'h12345678);
    req = 2'b00;
    tick;

    rst_n = 1'b0; req = 2'b11; we = 2'b00; addr0 = 32'hA0; addr1 = 32'hB0; bus_ready = 1'b1; bus_rdata = 32'hC0FFEE;
    #1;
    chk("t3_rst_rdata", rdata, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    nd = 0; first_addr = '0;
    for (int c = 1; c <= 12; c++) begin
      tick;
      if (c == 1) first_addr = bus_addr;
      if (done != 2'b00 && nd < 8) begin
        dseq[nd] = done;
        dcyc[nd] = c;
        nd++;
      end
    end
    req = 2'b00; bus_ready = 1'b0;
    chk("t3_ndone", nd, 4);
    chk("t3_first_addr", first_addr, 32'hA0);
    chk("t3_first_cyc", dcyc[0], 2);
    for (int k = 0; k < 4; k++) chk($sformatf("t3_seq%0d", k), 32'(dseq[k]), (k % 2 == 1) ? 32'd2 : 32'd1);
    for (int k = 1; k < 4; k++) chk($sformatf("t3_gap%0d", k), dcyc[k] - dcyc[k-1], 3);
    tick;
    tick;

    req = 2'b01; we = 2'b00; addr0 = 32'h200;
    tick;
    tick;
    chk("t6_pre_read", 32'(bus_read), 32'd1);
    rst_n = 1'b0; req = 2'b10; we = 2'b10; addr1 = 32'h300; wdata1 = 32'h77;
    #1;
    chk("t6_read_drop", 32'(bus_read), 32'd0);
    chk("t6_addr_clr", bus_addr, 32'd0);
    repeat (2) begin
      tick;
      chk("t6_no_done", 32'(done), 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    xact(1, 1'b0);
    chk("t6_done", 32'(dn), 32'd2);
    chk("t6_nwr", n_wr, 1);
    chk("t6_addr", a_seen, 32'h300);
    chk("t6_wdata", w_seen, 32'h77);
    chk("t6_lat", lat, 2);
    req = 2'b00;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
